// File: rtl/lsu_mem_port_if.sv
// Data-memory request/acknowledge bus between the load/store unit and data memory.
interface lsu_mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: byte/half/word accesses to data memory over req/ack, stalling the core meanwhile.
// Optional macro LSU_TIMEOUT_EN adds a TIMEOUT-cycle abort for a request that is never acknowledged.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    lsu_mem_port_if.master        mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("lsu_mem_port: TIMEOUT must be at least 2");
    end

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        misalign_c;
    logic        timeout_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted_c;
    logic [31:0] ld_c;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts unacknowledged REQ cycles; held at zero outside REQ.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != REQ) begin
            cnt_d = '0;
        end else if (!mem.mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout_c = (state_q == REQ) && !mem.mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Request decode: alignment, lane enables and store-data replication.
    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = wdata;
        case (size)
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign_c = addr[0];
                be_c       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata[15:0]}};
            end
            2'b10:   misalign_c = (addr[1:0] != 2'b00);
            default: misalign_c = 1'b1;
        endcase
    end

    // Load lane select and extension from the latched request.
    always_comb begin
        shifted_c = mem.mem_rdata >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   ld_c = uns_q ? {24'h0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   ld_c = uns_q ? {16'h0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: ld_c = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        be_d     = be_q;
        lo_d     = lo_q;
        size_d   = size_q;
        uns_d    = uns_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misalign_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = REQ;
                        req_d    = 1'b1;
                        we_d     = we;
                        maddr_d  = {addr[31:2], 2'b00};
                        mwdata_d = wdata_c;
                        be_d     = be_c;
                        lo_d     = addr[1:0];
                        size_d   = size;
                        uns_d    = unsigned_ld;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : ld_c;
                end else if (timeout_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            be_q     <= '0;
            lo_q     <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            be_q     <= be_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
        end
    end

    // Stall covers the accepting IDLE cycle so the instruction is held until DONE.
    assign busy          = ((state_q == IDLE) && start && !rst) || (state_q == REQ);
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = mwdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: loads, stores, misalignment, timeout and reset abort.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_port_if m ();

    lsu_mem_port #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .we          (we),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .mem         (m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction: start held from cycle 0 through the done cycle, ack only in ack_cyc.
    task automatic access(input string tag, input logic we_i, input logic [1:0] size_i,
                          input logic uns_i, input logic [31:0] addr_i, input logic [31:0] wdata_i,
                          input int ack_cyc, input logic [31:0] mrd, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int done_cyc);
        start = 1'b1; we = we_i; size = size_i; unsigned_ld = uns_i;
        addr = addr_i; wdata = wdata_i; m.mem_ack = 1'b0; m.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check({tag, ".busy0"}, 32'(busy), 32'd1);
        for (int c = 1; c < done_cyc; c++) begin
            next_cycle();
            m.mem_ack   = (c == ack_cyc);
            m.mem_rdata = (c == ack_cyc) ? mrd : 32'hDEAD_BEEF;
            #1;
            check({tag, ".req"},   32'(m.mem_req),  32'd1);
            check({tag, ".busy"},  32'(busy),       32'd1);
            check({tag, ".done"},  32'(done),       32'd0);
            check({tag, ".addr"},  m.mem_addr,      {addr_i[31:2], 2'b00});
            check({tag, ".we"},    32'(m.mem_we),   32'(we_i));
            check({tag, ".be"},    32'(m.mem_be),   32'(exp_be));
            check({tag, ".wdata"}, m.mem_wdata,     exp_wd);
        end
        next_cycle();
        m.mem_ack = 1'b0; m.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check({tag, ".done1"}, 32'(done),      32'd1);
        check({tag, ".err"},   32'(err),       32'(exp_err));
        check({tag, ".rdata"}, rdata,          exp_rdata);
        check({tag, ".reqlo"}, 32'(m.mem_req), 32'd0);
        check({tag, ".busyd"}, 32'(busy),      32'd0);
        next_cycle();
        start = 1'b0;
        #1;
        check({tag, ".idle"},  32'(done),      32'd0);
        check({tag, ".hold"},  rdata,          exp_rdata);
        check({tag, ".ibusy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0; m.mem_ack = 1'b0; m.mem_rdata = 32'h0;
        next_cycle();
        next_cycle();
        check("rst.busy",  32'(busy),        32'd0);
        check("rst.done",  32'(done),        32'd0);
        check("rst.err",   32'(err),         32'd0);
        check("rst.rdata", rdata,            32'd0);
        check("rst.req",   32'(m.mem_req),   32'd0);
        check("rst.addr",  m.mem_addr,       32'd0);
        check("rst.be",    32'(m.mem_be),    32'd0);
        rst = 1'b0; start = 1'b0; m.mem_ack = 1'b1;
        next_cycle();
        m.mem_ack = 1'b0;
        #1;
        check("stray_ack.done", 32'(done),      32'd0);
        check("stray_ack.req",  32'(m.mem_req), 32'd0);

        access("lb",   1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000,
               1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0, 2);
        access("lbu",  1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000,
               1'b0, 32'h0000_0080, 4'b1000, 32'h0, 2);
        access("sh",   1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 4, 32'h0,
               1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD, 5);
        access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0,
               1'b1, 32'h0, 4'b0000, 32'h0, 1);
        access("lh_pos", 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 1, 32'h8001_7FFF,
               1'b0, 32'hFFFF_8001, 4'b1100, 32'h0, 2);
        access("ill",  1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h0,
               1'b1, 32'h0, 4'b0000, 32'h0, 1);
        access("lhu",  1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'h0, 1, 32'h1234_F00D,
               1'b0, 32'h0000_F00D, 4'b0011, 32'h0, 2);
        access("lw",   1'b0, 2'b10, 1'b1, 32'h0000_5000, 32'h0, 2, 32'h89AB_CDEF,
               1'b0, 32'h89AB_CDEF, 4'b1111, 32'h0, 3);
        access("sb",   1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h0000_00A5, 1, 32'hFFFF_FFFF,
               1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 2);
        access("sw",   1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hCAFE_F00D, 3, 32'h0,
               1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D, 4);
        access("lb_pos", 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, 1, 32'h0000_7F00,
               1'b0, 32'h0000_007F, 4'b0010, 32'h0, 2);
        access("sh_mis", 1'b1, 2'b01, 1'b0, 32'h0000_2003, 32'h1111_2222, 0, 32'h0,
               1'b1, 32'h0, 4'b0000, 32'h0, 1);
`ifdef LSU_TIMEOUT_EN
        access("tmo",  1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h5555_AAAA, 0, 32'h0,
               1'b1, 32'h0, 4'b1111, 32'h5555_AAAA, 5);
        access("tmo_ack", 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 4, 32'h1357_9BDF,
               1'b0, 32'h1357_9BDF, 4'b1111, 32'h0, 5);
`else
        access("slow_ack", 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 7, 32'h1357_9BDF,
               1'b0, 32'h1357_9BDF, 4'b1111, 32'h0, 8);
`endif

        // Reset during a pending load aborts it without a done pulse.
        start = 1'b1; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h0000_9000;
        next_cycle();
        start = 1'b0;
        #1;
        check("rstreq.req1", 32'(m.mem_req), 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstreq.req",   32'(m.mem_req), 32'd0);
        check("rstreq.done",  32'(done),      32'd0);
        check("rstreq.busy",  32'(busy),      32'd0);
        check("rstreq.rdata", rdata,          32'd0);
        check("rstreq.addr",  m.mem_addr,     32'd0);
        next_cycle();
        access("after_rst", 1'b0, 2'b01, 1'b0, 32'h0000_9002, 32'h0, 1, 32'h7FFE_0000,
               1'b0, 32'h0000_7FFE, 4'b1100, 32'h0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
